// File: rtl/gpu_pkg.sv
// Shared types and constants for the primitive sequencer and its segment table.
package gpu_pkg;

  localparam int unsigned SCREEN_MAX_X = 640;
  localparam int unsigned SCREEN_MAX_Y = 480;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } vertex_t;

  typedef enum logic [1:0] {
    PRIM_LINE,
    PRIM_TRI,
    PRIM_RECT,
    PRIM_RSVD
  } prim_t;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StIssue,
    StWait,
    StNext,
    StFinish
  } seq_state_t;

  function automatic logic vertex_ok(vertex_t v, int unsigned max_x, int unsigned max_y);
    return (32'(v.x) <= max_x) && (32'(v.y) <= max_y);
  endfunction

  function automatic logic [1:0] last_seg(prim_t t);
    case (t)
      PRIM_TRI:  return 2'd2;
      PRIM_RECT: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/prim_seg_rom.sv
// Maps (primitive type, segment index, vertices) to one {x0, y0, x1, y1} segment.
module prim_seg_rom
  import gpu_pkg::*;
(
  input  prim_t       prim_i,
  input  logic [1:0]  seg_i,
  input  vertex_t     v0_i,
  input  vertex_t     v1_i,
  input  vertex_t     v2_i,
  output logic [37:0] seg_o
);

  vertex_t a;
  vertex_t b;

  always_comb begin
    a = v0_i;
    b = v1_i;
    case (prim_i)
      PRIM_TRI: begin
        case (seg_i)
          2'd0: begin
            a = v0_i;
            b = v1_i;
          end
          2'd1: begin
            a = v1_i;
            b = v2_i;
          end
          default: begin
            a = v2_i;
            b = v0_i;
          end
        endcase
      end
      PRIM_RECT: begin
        // v0 and v1 are opposite corners; walk the outline clockwise from v0.
        case (seg_i)
          2'd0: begin
            a = '{x: v0_i.x, y: v0_i.y};
            b = '{x: v1_i.x, y: v0_i.y};
          end
          2'd1: begin
            a = '{x: v1_i.x, y: v0_i.y};
            b = '{x: v1_i.x, y: v1_i.y};
          end
          2'd2: begin
            a = '{x: v1_i.x, y: v1_i.y};
            b = '{x: v0_i.x, y: v1_i.y};
          end
          default: begin
            a = '{x: v0_i.x, y: v1_i.y};
            b = '{x: v0_i.x, y: v0_i.y};
          end
        endcase
      end
      default: begin
        a = v0_i;
        b = v1_i;
      end
    endcase
    seg_o = {a, b};
  end

endmodule

// File: rtl/prim_sequencer.sv
// Command-level controller: splits a line/triangle/rectangle into line segments
// and feeds them one at a time to the bresenline engine.
module prim_sequencer
  import gpu_pkg::*;
#(
  parameter int unsigned MAX_X        = SCREEN_MAX_X,
  parameter int unsigned MAX_Y        = SCREEN_MAX_Y,
  parameter int unsigned GUARD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [18:0] cmd_v0,
  input  logic [18:0] cmd_v1,
  input  logic [18:0] cmd_v2,
  input  logic        abort,
  input  logic        fb_stall,
  output logic [37:0] le_positions,
  output logic        le_start,
  input  logic        le_done,
  output logic        le_stop,
  output logic        busy,
  output logic        prim_done,
  output logic        err
);

  localparam int unsigned GuardW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

  seq_state_t        state_q, state_d;
  prim_t             type_q, type_d;
  vertex_t           v0_q, v0_d;
  vertex_t           v1_q, v1_d;
  vertex_t           v2_q, v2_d;
  logic [1:0]        seg_cnt_q, seg_cnt_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic [37:0]       pos_q, pos_d;
  logic              err_q, err_d;

  logic              reject;
  logic              load_pos;
  logic [1:0]        seg_sel;
  logic [37:0]       rom_seg;

  assign reject = (type_q == PRIM_RSVD) ||
                  !vertex_ok(v0_q, MAX_X, MAX_Y) ||
                  !vertex_ok(v1_q, MAX_X, MAX_Y) ||
                  ((type_q == PRIM_TRI) && !vertex_ok(v2_q, MAX_X, MAX_Y));

  // Table index of the segment about to be issued: 0 from CHECK, seg_cnt+1 from NEXT.
  assign seg_sel = (state_q == StNext) ? (seg_cnt_q + 2'd1) : 2'd0;

  prim_seg_rom u_seg_rom (
    .prim_i (type_q),
    .seg_i  (seg_sel),
    .v0_i   (v0_q),
    .v1_i   (v1_q),
    .v2_i   (v2_q),
    .seg_o  (rom_seg)
  );

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    seg_cnt_d = seg_cnt_q;
    guard_d   = guard_q;
    pos_d     = pos_q;
    err_d     = err_q;
    load_pos  = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          type_d  = prim_t'(cmd_type);
          v0_d    = vertex_t'(cmd_v0);
          v1_d    = vertex_t'(cmd_v1);
          v2_d    = vertex_t'(cmd_v2);
          err_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (reject) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          seg_cnt_d = 2'd0;
          load_pos  = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        guard_d = GuardW'(GUARD_CYCLES);
        state_d = StWait;
      end
      StWait: begin
        // Early cycles may still see the previous segment's done.
        if (guard_q != '0) begin
          guard_d = guard_q - 1'b1;
        end else if (le_done) begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (seg_cnt_q == last_seg(type_q)) begin
          state_d = StFinish;
        end else begin
          seg_cnt_d = seg_cnt_q + 2'd1;
          load_pos  = 1'b1;
          state_d   = StIssue;
        end
      end
      StFinish: begin
        seg_cnt_d = 2'd0;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      seg_cnt_d = 2'd0;
      load_pos  = 1'b0;
    end

    if (load_pos) begin
      pos_d = rom_seg;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      type_q    <= PRIM_LINE;
      v0_q      <= '0;
      v1_q      <= '0;
      v2_q      <= '0;
      seg_cnt_q <= 2'd0;
      guard_q   <= '0;
      pos_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      seg_cnt_q <= seg_cnt_d;
      guard_q   <= guard_d;
      pos_q     <= pos_d;
      err_q     <= err_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign cmd_ready    = (state_q == StIdle);
  assign le_start     = (state_q == StIssue);
  assign le_positions = pos_q;
  assign le_stop      = busy & (fb_stall | abort);
  assign prim_done    = (state_q == StFinish) & ~abort;
  assign err          = prim_done & err_q;

endmodule
